// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM and the ALU control decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_BNEBR,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_RTYPE = 3'b001;
    localparam logic [2:0] ALUOP_SUB   = 3'b010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on the memory handshake and are guarded by the timeout.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes; expired flags TIMEOUT_CYCLES wait cycles seen.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Optional feature: define BNE_SUPPORT_EN to decode bne (opcode 000101) instead of faulting.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUop,
    output logic       Fault
);

    state_t state, next_state;
    logic   expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Any state change restarts the count, so each memory state starts its wait from zero.
    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (next_state != state),
        .en      (is_mem_wait(state) && !MemReady),
        .expired (expired)
    );

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        PCSrc      = PCSRC_ALU;
        ALUop      = ALUOP_ADD;
        Fault      = 1'b0;

        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady)     next_state = S_DECODE;
                else if (expired) next_state = S_FAULT;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SL2;
                case (Opcode)
                    OP_RTYPE:      next_state = S_EXEC;
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_BEQ:        next_state = S_BRANCH;
`ifdef BNE_SUPPORT_EN
                    OP_BNE:        next_state = S_BNEBR;
`endif
                    OP_ADDI:       next_state = S_ADDIEX;
                    OP_J:          next_state = S_JUMP;
                    default:       next_state = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady)     next_state = S_MEMWB;
                else if (expired) next_state = S_FAULT;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady)     next_state = S_FETCH;
                else if (expired) next_state = S_FAULT;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUop      = ALUOP_RTYPE;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH, S_BNEBR: begin
                ALUSrcA    = 1'b1;
                ALUop      = ALUOP_SUB;
                PCSrc      = PCSRC_ALUOUT;
                PCWrite    = (state == S_BNEBR) ? !Zero : Zero;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                PCWrite    = 1'b1;
                next_state = S_FETCH;
            end
            S_FAULT: Fault = 1'b1;
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed and randomized checks of multicycle_control against a per-instruction cycle model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Opcode = 6'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Fault;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUop;
    logic [17:0] obs;

    int n_assert = 0;
    int n_fail = 0;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011, T_BEQ = 6'b000100,
                           T_BNE = 6'b000101, T_ADDI = 6'b001000, T_J = 6'b000010, T_BAD = 6'b111111;
    localparam logic [17:0] W_ZERO = 18'h0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUop(ALUop), .Fault(Fault)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                  ALUSrcA, ALUSrcB, PCSrc, ALUop, Fault};

    function automatic logic [17:0] cw(input logic pcw, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
                                       input logic [1:0] srcb, pcsrc, input logic [2:0] aluop,
                                       input logic flt);
        return {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcsrc, aluop, flt};
    endfunction

    function automatic logic [17:0] w_fetch(input logic mr);
        return cw(mr, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [17:0] w_branch(input logic take);
        return cw(take, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b010, 0);
    endfunction

    localparam logic [17:0] W_DECODE = {9'b0, 2'b11, 2'b00, 3'b000, 1'b0};
    localparam logic [17:0] W_MEMADR = {8'b0, 1'b1, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [17:0] W_MEMRD  = {1'b0, 1'b1, 1'b1, 6'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [17:0] W_MEMWB  = {5'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [17:0] W_MEMWR  = {1'b0, 1'b1, 1'b0, 1'b1, 5'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [17:0] W_EXEC   = {8'b0, 1'b1, 2'b00, 2'b00, 3'b001, 1'b0};
    localparam logic [17:0] W_ALUWB  = {6'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [17:0] W_ADDIEX = {8'b0, 1'b1, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [17:0] W_ADDIWB = {7'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [17:0] W_JUMP   = {1'b1, 8'b0, 2'b00, 2'b10, 3'b000, 1'b0};
    localparam logic [17:0] W_FAULT  = 18'h1;

    task automatic check(input logic [17:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare at the falling edge, return just after the next rising edge.
    task automatic step(input logic mr, input logic z, input logic [17:0] exp, input string tag);
        MemReady = mr;
        Zero = z;
        @(negedge clk);
        check(exp, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step(1'b1, 1'b0, W_ZERO, "reset");
        rst = 1'b0;
        step(1'b1, 1'b0, W_ZERO, "idle");
    endtask

    // Expected cycle sequence of one instruction, starting in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fst, input int mst);
        Opcode = op;
        repeat (fst) step(1'b0, z, w_fetch(1'b0), "fetch_wait");
        step(1'b1, z, w_fetch(1'b1), "fetch");
        step(1'($urandom_range(0, 1)), z, W_DECODE, "decode");
        case (op)
            T_R: begin
                step(1'($urandom_range(0, 1)), z, W_EXEC, "exec");
                step(1'($urandom_range(0, 1)), z, W_ALUWB, "aluwb");
            end
            T_LW: begin
                step(1'($urandom_range(0, 1)), z, W_MEMADR, "lw_memadr");
                repeat (mst) step(1'b0, z, W_MEMRD, "memrd_wait");
                step(1'b1, z, W_MEMRD, "memrd");
                step(1'($urandom_range(0, 1)), z, W_MEMWB, "memwb");
            end
            T_SW: begin
                step(1'($urandom_range(0, 1)), z, W_MEMADR, "sw_memadr");
                repeat (mst) step(1'b0, z, W_MEMWR, "memwr_wait");
                step(1'b1, z, W_MEMWR, "memwr");
            end
            T_BEQ: step(1'($urandom_range(0, 1)), z, w_branch(z), "beq");
            T_ADDI: begin
                step(1'($urandom_range(0, 1)), z, W_ADDIEX, "addiex");
                step(1'($urandom_range(0, 1)), z, W_ADDIWB, "addiwb");
            end
            T_J: step(1'($urandom_range(0, 1)), z, W_JUMP, "jump");
            default: step(1'($urandom_range(0, 1)), z, W_FAULT, "illegal");
        endcase
    endtask

    initial begin
        logic [5:0] legal_ops [6];
        legal_ops = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J};

        @(posedge clk);
        #1;
        do_reset();

        // Directed instructions
        run_instr(T_R, 1'b0, 0, 0);
        run_instr(T_LW, 1'b0, 0, 3);
        run_instr(T_BEQ, 1'b1, 0, 0);
        run_instr(T_BEQ, 1'b0, 0, 0);
        run_instr(T_ADDI, 1'b0, 2, 0);
        run_instr(T_SW, 1'b1, 0, 2);
        run_instr(T_J, 1'b0, 1, 0);

        // Randomized instruction stream with random handshake stalls
        for (int i = 0; i < 40; i++) begin
            run_instr(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Ready arriving on the last allowed wait cycle wins over the timeout
        Opcode = T_J;
        repeat (15) step(1'b0, 1'b0, w_fetch(1'b0), "to_wait");
        step(1'b1, 1'b0, w_fetch(1'b1), "to_ready_edge");
        step(1'b0, 1'b0, W_DECODE, "to_decode");
        step(1'b0, 1'b0, W_JUMP, "to_jump");
        run_instr(T_J, 1'b0, 15, 0);
        run_instr(T_LW, 1'b1, 0, 15);

        // Timeout: 16th consecutive wait cycle faults
        Opcode = T_J;
        repeat (16) step(1'b0, 1'b0, w_fetch(1'b0), "to_wait_fault");
        repeat (20) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W_FAULT, "to_fault_hold");
        do_reset();

        // Illegal opcode faults and holds until reset
        run_instr(T_BAD, 1'b0, 0, 0);
        repeat (20) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W_FAULT, "bad_fault_hold");
        do_reset();

        // bne
`ifdef BNE_SUPPORT_EN
        Opcode = T_BNE;
        step(1'b1, 1'b1, w_fetch(1'b1), "bne_fetch");
        step(1'b1, 1'b1, W_DECODE, "bne_decode");
        step(1'b1, 1'b1, w_branch(1'b0), "bne_zero1");
        step(1'b1, 1'b0, w_fetch(1'b1), "bne_fetch2");
        step(1'b1, 1'b0, W_DECODE, "bne_decode2");
        step(1'b1, 1'b0, w_branch(1'b1), "bne_zero0");
`else
        Opcode = T_BNE;
        step(1'b1, 1'b0, w_fetch(1'b1), "bne_fetch");
        step(1'b1, 1'b0, W_DECODE, "bne_decode");
        step(1'b1, 1'b0, W_FAULT, "bne_illegal");
        do_reset();
`endif

        // Asynchronous reset mid-store drops MemWrite immediately
        Opcode = T_SW;
        step(1'b1, 1'b0, w_fetch(1'b1), "mr_fetch");
        step(1'b1, 1'b0, W_DECODE, "mr_decode");
        step(1'b1, 1'b0, W_MEMADR, "mr_memadr");
        MemReady = 1'b0;
        @(negedge clk);
        check(W_MEMWR, "mr_memwr");
        rst = 1'b1;
        #1;
        check(W_ZERO, "mr_async_reset");
        @(posedge clk);
        #1;
        do_reset();
        run_instr(T_R, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
